// File: rtl/imm_materializer.sv
// Emits the shortest ADDI / LUI / LUI+LBI instruction sequence that loads a
// 16-bit constant into a register, one 16-bit word per valid/ready handshake.
module imm_materializer #(
  parameter logic [3:0] ZERO_REG    = 4'h0,
  parameter bit         ENABLE_ADDI = 1'b1,
  parameter int         CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             In_ReqValid,
  input  logic [3:0]       In_Rd,
  input  logic [15:0]      In_Value,
  output logic             Out_ReqReady,
  output logic [15:0]      Out_Inst,
  output logic             Out_InstValid,
  input  logic             In_InstReady,
  output logic             Out_Busy,
  output logic [CNT_W-1:0] Out_EmitCount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMIT1 = 2'd1;
  localparam logic [1:0] S_EMIT2 = 2'd2;

  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b1110;
  localparam logic [3:0] OP_LBI  = 4'b1111;

  logic [1:0]       state_q, state_d;
  logic [15:0]      inst_q, inst_d;
  logic             valid_q, valid_d;
  logic [3:0]       rd_q, rd_d;
  logic [15:0]      v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        in_small;
  logic [15:0] first_word;
  logic        pair_q;
  logic [15:0] lbi_word;
  logic        handshake;

  // v[15:3] all-equal means v fits a sign-extended 4-bit immediate.
  assign in_small = ENABLE_ADDI && ((&In_Value[15:3]) || ~(|In_Value[15:3]));

  always_comb begin
    first_word = {In_Rd, In_Value[15:8], OP_LUI};
    if (in_small) begin
      first_word = {In_Rd, ZERO_REG, In_Value[3:0], OP_ADDI};
    end
  end

  // The captured value needs a second word unless it was ADDI or LUI-only.
  assign pair_q = !(ENABLE_ADDI && ((&v_q[15:3]) || ~(|v_q[15:3])))
                  && (v_q[7:0] != 8'h00);
  assign lbi_word  = {rd_q, v_q[7:0], OP_LBI};
  assign handshake = valid_q && In_InstReady;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    if (handshake) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (In_ReqValid) begin
          rd_d    = In_Rd;
          v_d     = In_Value;
          inst_d  = first_word;
          valid_d = 1'b1;
          state_d = S_EMIT1;
        end
      end
      S_EMIT1: begin
        if (handshake) begin
          if (pair_q) begin
            inst_d  = lbi_word;
            state_d = S_EMIT2;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT2: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      inst_q  <= 16'h0000;
      valid_q <= 1'b0;
      rd_q    <= 4'h0;
      v_q     <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Out_ReqReady  = (state_q == S_IDLE);
  assign Out_Busy      = (state_q != S_IDLE);
  assign Out_Inst      = inst_q;
  assign Out_InstValid = valid_q;
  assign Out_EmitCount = cnt_q;

endmodule

// File: tb/tb_imm_materializer.sv
// Directed-vector bench for imm_materializer: one instance with ADDI enabled,
// one with it disabled, sharing clock and reset.
module tb_imm_materializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic [3:0]  a_rd = 4'h0, b_rd = 4'h0;
  logic [15:0] a_value = 16'h0, b_value = 16'h0;
  logic        a_inst_ready = 1'b0, b_inst_ready = 1'b0;
  logic        a_req_ready, b_req_ready;
  logic [15:0] a_inst, b_inst;
  logic        a_inst_valid, b_inst_valid;
  logic        a_busy, b_busy;
  logic [15:0] a_cnt, b_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt [2] = '{0, 0};

  imm_materializer dut_a (
    .CLK(clk), .Reset_n(rst_n),
    .In_ReqValid(a_req_valid), .In_Rd(a_rd), .In_Value(a_value),
    .Out_ReqReady(a_req_ready), .Out_Inst(a_inst), .Out_InstValid(a_inst_valid),
    .In_InstReady(a_inst_ready), .Out_Busy(a_busy), .Out_EmitCount(a_cnt)
  );

  imm_materializer #(.ENABLE_ADDI(1'b0)) dut_b (
    .CLK(clk), .Reset_n(rst_n),
    .In_ReqValid(b_req_valid), .In_Rd(b_rd), .In_Value(b_value),
    .Out_ReqReady(b_req_ready), .Out_Inst(b_inst), .Out_InstValid(b_inst_valid),
    .In_InstReady(b_inst_ready), .Out_Busy(b_busy), .Out_EmitCount(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic drive(input int sel, input logic vld, input logic [3:0] rd,
                       input logic [15:0] v, input logic rdy);
    if (sel == 0) begin
      a_req_valid = vld; a_rd = rd; a_value = v; a_inst_ready = rdy;
    end else begin
      b_req_valid = vld; b_rd = rd; b_value = v; b_inst_ready = rdy;
    end
  endtask

  task automatic obs(input int sel, output logic rr, output logic [15:0] inst,
                     output logic iv, output logic bz, output logic [15:0] cnt);
    if (sel == 0) begin
      rr = a_req_ready; inst = a_inst; iv = a_inst_valid; bz = a_busy; cnt = a_cnt;
    end else begin
      rr = b_req_ready; inst = b_inst; iv = b_inst_valid; bz = b_busy; cnt = b_cnt;
    end
  endtask

  // One request with consumer always ready; words checked on consecutive cycles.
  task automatic run_req(input int sel, input string name, input logic [3:0] rd,
                         input logic [15:0] v, input int nwords,
                         input logic [15:0] w0, input logic [15:0] w1);
    logic rr, iv, bz;
    logic [15:0] inst, cnt;
    @(negedge clk);
    obs(sel, rr, inst, iv, bz, cnt);
    check({name, ".ready_before"}, {31'b0, rr}, 32'd1);
    drive(sel, 1'b1, rd, v, 1'b1);
    @(negedge clk);
    drive(sel, 1'b0, 4'h0, 16'h0, 1'b1);
    obs(sel, rr, inst, iv, bz, cnt);
    check({name, ".w0"}, {15'b0, iv, inst}, {16'h1, w0});
    check({name, ".busy"}, {31'b0, bz}, 32'd1);
    exp_cnt[sel]++;
    if (nwords == 2) begin
      @(negedge clk);
      obs(sel, rr, inst, iv, bz, cnt);
      check({name, ".w1"}, {15'b0, iv, inst}, {16'h1, w1});
      exp_cnt[sel]++;
    end
    @(negedge clk);
    obs(sel, rr, inst, iv, bz, cnt);
    check({name, ".done"}, {29'b0, iv, bz, rr}, 32'b001);
    check({name, ".count"}, {16'b0, cnt}, 32'(exp_cnt[sel]));
    drive(sel, 1'b0, 4'h0, 16'h0, 1'b0);
  endtask

  initial begin
    logic rr, iv, bz;
    logic [15:0] inst, cnt;

    #12;
    obs(0, rr, inst, iv, bz, cnt);
    check("reset.a", {iv, bz, rr, inst, cnt[12:0]}, {3'b001, 16'h0, 13'h0});
    obs(1, rr, inst, iv, bz, cnt);
    check("reset.b", {iv, bz, rr, inst, cnt[12:0]}, {3'b001, 16'h0, 13'h0});
    @(negedge clk);
    rst_n = 1'b1;

    run_req(0, "addi_m1", 4'd2, 16'hFFFF, 1, 16'h20F4, 16'h0);
    run_req(0, "addi_3", 4'd1, 16'h0003, 1, 16'h1034, 16'h0);
    run_req(0, "lui_0d", 4'd13, 16'h0D00, 1, 16'hD0DE, 16'h0);
    run_req(0, "lui_eb", 4'd7, 16'hEB00, 1, 16'h7EBE, 16'h0);
    run_req(0, "pair_4a", 4'd12, 16'h004A, 2, 16'hC00E, 16'hC4AF);
    run_req(0, "pair_abcd", 4'd3, 16'hABCD, 2, 16'h3ABE, 16'h3CDF);
    run_req(0, "addi_7", 4'd4, 16'h0007, 1, 16'h4074, 16'h0);
    run_req(0, "pair_8", 4'd4, 16'h0008, 2, 16'h400E, 16'h408F);
    run_req(0, "addi_m8", 4'd5, 16'hFFF8, 1, 16'h5084, 16'h0);
    run_req(1, "noaddi_m1", 4'd2, 16'hFFFF, 2, 16'h2FFE, 16'h2FFF);
    run_req(1, "noaddi_5", 4'd0, 16'h0005, 2, 16'h000E, 16'h005F);

    // Backpressure on the first word with a stray request in the middle.
    @(negedge clk);
    drive(0, 1'b1, 4'd12, 16'h004A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) drive(0, 1'b1, 4'd5, 16'h1234, 1'b0);
      else drive(0, 1'b0, 4'd0, 16'h0, 1'b0);
      obs(0, rr, inst, iv, bz, cnt);
      check($sformatf("bp.hold%0d", i), {14'b0, rr, iv, inst}, {16'h1, 16'hC00E});
    end
    drive(0, 1'b0, 4'd0, 16'h0, 1'b1);
    exp_cnt[0]++;
    @(negedge clk);
    obs(0, rr, inst, iv, bz, cnt);
    check("bp.w1", {15'b0, iv, inst}, {16'h1, 16'hC4AF});
    exp_cnt[0]++;
    @(negedge clk);
    obs(0, rr, inst, iv, bz, cnt);
    check("bp.done", {29'b0, iv, bz, rr}, 32'b001);
    check("bp.count", {16'b0, cnt}, 32'(exp_cnt[0]));

    // Reset pulsed between the LUI and LBI handshakes.
    drive(0, 1'b1, 4'd3, 16'hABCD, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 16'h0, 1'b1);
    obs(0, rr, inst, iv, bz, cnt);
    check("rst.lui", {15'b0, iv, inst}, {16'h1, 16'h3ABE});
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 16'h0, 1'b0);
    obs(0, rr, inst, iv, bz, cnt);
    check("rst.lbi_pending", {15'b0, iv, inst}, {16'h1, 16'h3CDF});
    #2 rst_n = 1'b0;
    #1;
    obs(0, rr, inst, iv, bz, cnt);
    check("rst.async", {iv, bz, rr, inst, cnt[12:0]}, {3'b001, 16'h0, 13'h0});
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 4'd0, 16'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs(0, rr, inst, iv, bz, cnt);
      check($sformatf("rst.after%0d", i), {iv, bz, rr, inst, cnt[12:0]},
            {3'b001, 16'h0, 13'h0});
    end
    exp_cnt[0] = 0;
    run_req(0, "post_rst", 4'd9, 16'h0100, 1, 16'h901E, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
